// File: rtl/rx_sync_controller.sv
// Receive-side frame synchronizer: waits for peak-detector lock, reduces the
// detector offset to a symbol phase, then strobes and captures a payload.
module rx_sync_controller #(
  parameter int unsigned WAVELENGTH      = 8,
  parameter int unsigned PREAMBLE_LENGTH = 4,
  parameter int unsigned PAYLOAD_BITS    = 8,
  parameter int unsigned SEARCH_TIMEOUT  = 1024,
  localparam int unsigned SAMPLE_COUNT   = WAVELENGTH * PREAMBLE_LENGTH,
  localparam int unsigned OFF_W          = $clog2(SAMPLE_COUNT) + 1,
  localparam int unsigned PH_W           = $clog2(WAVELENGTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    det_ready,
  input  logic [OFF_W-1:0]        det_offset,
  input  logic                    bit_in,
  output logic                    det_clear,
  output logic [PH_W-1:0]         phase,
  output logic                    symbol_strobe,
  output logic [PAYLOAD_BITS-1:0] payload,
  output logic                    payload_valid,
  output logic                    busy,
  output logic                    timeout,
  output logic [2:0]              state
);

  localparam int unsigned SC_W = $clog2(SEARCH_TIMEOUT);
  localparam int unsigned BC_W = $clog2(PAYLOAD_BITS + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEARCH  = 3'd1,
    ST_ALIGN   = 3'd2,
    ST_RECEIVE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [SC_W-1:0]         search_q, search_d;
  logic [OFF_W-1:0]        work_q, work_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [PH_W-1:0]         sym_q, sym_d;
  logic [BC_W-1:0]         bit_q, bit_d;
  logic [PAYLOAD_BITS-1:0] payload_q, payload_d;
  logic                    timeout_q, timeout_d;
  logic                    strobe_q, strobe_d;
  logic                    valid_q, valid_d;
  logic                    clear_q, clear_d;
  logic                    busy_q, busy_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      search_q  <= '0;
      work_q    <= '0;
      phase_q   <= '0;
      sym_q     <= '0;
      bit_q     <= '0;
      payload_q <= '0;
      timeout_q <= 1'b0;
      strobe_q  <= 1'b0;
      valid_q   <= 1'b0;
      clear_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      search_q  <= search_d;
      work_q    <= work_d;
      phase_q   <= phase_d;
      sym_q     <= sym_d;
      bit_q     <= bit_d;
      payload_q <= payload_d;
      timeout_q <= timeout_d;
      strobe_q  <= strobe_d;
      valid_q   <= valid_d;
      clear_q   <= clear_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic; strobe_q already marks the cycle where sym_q == phase_q
  always_comb begin
    state_d   = state_q;
    search_d  = search_q;
    work_d    = work_q;
    phase_d   = phase_q;
    sym_d     = sym_q;
    bit_d     = bit_q;
    payload_d = payload_q;
    timeout_d = timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d   = ST_SEARCH;
          search_d  = '0;
          timeout_d = 1'b0;
        end
      end
      ST_SEARCH: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (det_ready) begin
          work_d  = det_offset;
          state_d = ST_ALIGN;
        end else if (search_q == SC_W'(SEARCH_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          search_d = search_q + SC_W'(1);
        end
      end
      ST_ALIGN: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (work_q >= OFF_W'(WAVELENGTH)) begin
          work_d = work_q - OFF_W'(WAVELENGTH);
        end else begin
          phase_d = work_q[PH_W-1:0];
          sym_d   = '0;
          bit_d   = '0;
          state_d = ST_RECEIVE;
        end
      end
      ST_RECEIVE: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else begin
          sym_d = (sym_q == PH_W'(WAVELENGTH - 1)) ? '0 : sym_q + PH_W'(1);
          if (strobe_q) begin
            payload_d = (payload_q << 1) | PAYLOAD_BITS'(bit_in);
            bit_d     = bit_q + BC_W'(1);
            if (bit_q == BC_W'(PAYLOAD_BITS - 1)) begin
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs are derived from the upcoming state
  always_comb begin
    strobe_d = 1'b0;
    valid_d  = 1'b0;
    clear_d  = 1'b0;
    busy_d   = 1'b0;
    strobe_d = (state_d == ST_RECEIVE) && (sym_d == phase_d);
    valid_d  = (state_d == ST_DONE);
    clear_d  = (state_d == ST_IDLE) || (state_d == ST_DONE);
    busy_d   = (state_d != ST_IDLE);
  end

  assign det_clear     = clear_q;
  assign phase         = phase_q;
  assign symbol_strobe = strobe_q;
  assign payload       = payload_q;
  assign payload_valid = valid_q;
  assign busy          = busy_q;
  assign timeout       = timeout_q;
  assign state         = state_q;

endmodule
